// File: rtl/prtc_if.sv
// Host register bus for the PRTC: one-clock access strobe, register select and data in/out.
interface prtc_if;
    logic       addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       rw;
    logic       strobe;

    modport master (output addr, din, rw, strobe, input dout);
    modport slave  (input addr, din, rw, strobe, output dout);
endinterface

// File: rtl/prtc.sv
// PRTC: host DATA/CTL register pair driving a command protocol onto a 256x8 BRAM and a
// 32-bit seconds counter; each transfer holds busy for BUSY_CEN cen pulses before it acts.
module prtc #(
    parameter int unsigned CEN_HZ   = 2500000,
    parameter int unsigned BUSY_CEN = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  cen,
    prtc_if.slave bus
);
    localparam int unsigned TW = (BUSY_CEN > 1) ? $clog2(BUSY_CEN) : 1;
    localparam int unsigned PW = (CEN_HZ > 1) ? $clog2(CEN_HZ) : 1;

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e       r_state, w_state;
    logic [7:0]   r_data, w_data;
    logic         r_busy, w_busy;
    logic         r_dir, w_dir;
    logic         r_last, w_last;
    logic [7:0]   r_dout, w_dout;
    logic [2:0]   r_addr_hi, w_addr_hi;
    logic [7:0]   r_bram_addr, w_bram_addr;
    logic         r_pend_rd, w_pend_rd;
    logic         r_sec_sel, w_sec_sel;
    logic [1:0]   r_sec_byte, w_sec_byte;
    logic [TW-1:0] r_timer, w_timer;
    logic [PW-1:0] r_presc, w_presc;
    logic [31:0]  r_sec, w_sec;
    logic         w_done;
    logic         w_mem_we;
    logic [7:0]   w_sec_rd;

    // BRAM contents survive reset; only the power-on value is defined.
    logic [7:0] r_mem [256] = '{default: 8'h00};

    assign w_sec_rd = r_sec[{r_sec_byte, 3'b000} +: 8];
    assign bus.dout = r_dout;

    always_comb begin
        w_state     = r_state;
        w_data      = r_data;
        w_busy      = r_busy;
        w_dir       = r_dir;
        w_last      = r_last;
        w_dout      = r_dout;
        w_addr_hi   = r_addr_hi;
        w_bram_addr = r_bram_addr;
        w_pend_rd   = r_pend_rd;
        w_sec_sel   = r_sec_sel;
        w_sec_byte  = r_sec_byte;
        w_timer     = r_timer;
        w_presc     = r_presc;
        w_sec       = r_sec;
        w_done      = 1'b0;
        w_mem_we    = 1'b0;

        if (cen) begin
            if (r_presc == PW'(CEN_HZ - 1)) begin
                w_presc = '0;
                w_sec   = r_sec + 32'd1;
            end else begin
                w_presc = r_presc + PW'(1);
            end
        end

        if (r_busy && cen) begin
            if (r_timer == TW'(BUSY_CEN - 1)) begin
                w_done  = 1'b1;
                w_timer = '0;
                w_busy  = 1'b0;
            end else begin
                w_timer = r_timer + TW'(1);
            end
        end

        // Direction mismatches fall through every branch and complete as no-ops.
        if (w_done) begin
            unique case (r_state)
                StIdle: begin
                    if (!r_dir) begin
                        if (r_data[6:4] == 3'b000 && r_data[1:0] == 2'b01) begin
                            w_sec_sel  = 1'b1;
                            w_sec_byte = r_data[3:2];
                            w_pend_rd  = r_data[7];
                            w_state    = StData;
                        end else if (r_data[6:3] == 4'b0111) begin
                            w_sec_sel  = 1'b0;
                            w_addr_hi  = r_data[2:0];
                            w_pend_rd  = r_data[7];
                            w_state    = StAddr;
                        end
                    end
                end
                StAddr: begin
                    if (!r_dir) begin
                        w_bram_addr = {r_addr_hi, r_data[6:2]};
                        w_state     = StData;
                    end
                end
                StData: begin
                    if (r_dir && r_pend_rd) begin
                        w_data  = r_sec_sel ? w_sec_rd : r_mem[r_bram_addr];
                        w_state = StIdle;
                    end else if (!r_dir && !r_pend_rd) begin
                        if (r_sec_sel) begin
                            // Byte write replaces any tick on this edge.
                            w_sec = r_sec;
                            w_sec[{r_sec_byte, 3'b000} +: 8] = r_data;
                            if (r_sec_byte == 2'd0) w_presc = '0;
                        end else begin
                            w_mem_we = 1'b1;
                        end
                        w_state = StIdle;
                    end
                end
                default: w_state = StIdle;
            endcase
        end

        if (bus.strobe) begin
            if (bus.rw) begin
                w_dout = bus.addr ? {r_busy, r_dir, r_last, 5'b0} : r_data;
            end else if (!r_busy) begin
                if (!bus.addr) begin
                    w_data = bus.din;
                end else begin
                    w_busy  = bus.din[7];
                    w_dir   = bus.din[6];
                    w_last  = bus.din[5];
                    w_timer = '0;
                    if (!bus.din[7] && bus.din[5]) w_state = StIdle;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_data      <= '0;
            r_busy      <= 1'b0;
            r_dir       <= 1'b0;
            r_last      <= 1'b0;
            r_dout      <= '0;
            r_addr_hi   <= '0;
            r_bram_addr <= '0;
            r_pend_rd   <= 1'b0;
            r_sec_sel   <= 1'b0;
            r_sec_byte  <= '0;
            r_timer     <= '0;
            r_presc     <= '0;
            r_sec       <= '0;
        end else begin
            r_state     <= w_state;
            r_data      <= w_data;
            r_busy      <= w_busy;
            r_dir       <= w_dir;
            r_last      <= w_last;
            r_dout      <= w_dout;
            r_addr_hi   <= w_addr_hi;
            r_bram_addr <= w_bram_addr;
            r_pend_rd   <= w_pend_rd;
            r_sec_sel   <= w_sec_sel;
            r_sec_byte  <= w_sec_byte;
            r_timer     <= w_timer;
            r_presc     <= w_presc;
            r_sec       <= w_sec;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_bram_addr] <= r_data;
    end
endmodule

// File: tb/tb_prtc.sv
// Scoreboard bench for prtc: a transaction-level model predicts every host read, a negedge
// monitor compares dout against the queued predictions.
module tb_prtc;
    localparam int unsigned CEN_HZ   = 4;
    localparam int unsigned BUSY_CEN = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic cen = 1'b0;

    prtc_if bus ();

    prtc #(.CEN_HZ(CEN_HZ), .BUSY_CEN(BUSY_CEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state (phase: 0 idle, 1 waiting for address, 2 waiting for data).
    bit [7:0]  m_mem [256];
    bit [7:0]  m_data;
    bit        m_busy, m_dir, m_last;
    int        m_left;
    int        m_phase;
    bit        m_pend_rd, m_to_sec;
    int        m_sbyte;
    int        m_baddr;
    int        m_hi;
    bit [31:0] m_sec;
    int        m_presc;

    logic [7:0] exp_q [$];
    string      name_q [$];
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: dout=%02h expected=%02h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        string      nm;
        if (!rst_n) begin
            check("dout_in_reset", bus.dout, 8'h00);
        end else if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, bus.dout, e);
        end
    end

    task automatic model_reset();
        m_data = 0; m_busy = 0; m_dir = 0; m_last = 0; m_left = 0; m_phase = 0;
        m_pend_rd = 0; m_to_sec = 0; m_sbyte = 0; m_baddr = 0; m_hi = 0;
        m_sec = 0; m_presc = 0;
    endtask

    task automatic model_step(input bit st, input bit rw, input bit a, input bit [7:0] d,
                              input bit c, input string nm);
        bit [7:0]  data_n = m_data;
        bit        busy_n = m_busy, dir_n = m_dir, last_n = m_last;
        int        left_n = m_left, phase_n = m_phase, presc_n = m_presc;
        bit [31:0] sec_n = m_sec;
        int        cmd = int'(m_data) % 128;
        bit [31:0] mask;
        if (st && rw) begin
            exp_q.push_back(a ? {m_busy, m_dir, m_last, 5'b00000} : m_data);
            name_q.push_back(nm);
        end
        if (c) begin
            presc_n = m_presc + 1;
            if (presc_n == int'(CEN_HZ)) begin
                presc_n = 0;
                sec_n   = m_sec + 1;
            end
        end
        if (m_busy && c) begin
            left_n = m_left - 1;
            if (left_n == 0) begin
                busy_n = 0;
                if (m_phase == 0 && !m_dir) begin
                    if (cmd < 16 && cmd % 4 == 1) begin
                        m_to_sec = 1; m_sbyte = cmd / 4; m_pend_rd = m_data[7]; phase_n = 2;
                    end else if (cmd >= 'h38 && cmd <= 'h3F) begin
                        m_to_sec = 0; m_hi = cmd - 'h38; m_pend_rd = m_data[7]; phase_n = 1;
                    end
                end else if (m_phase == 1 && !m_dir) begin
                    m_baddr = m_hi * 32 + cmd / 4;
                    phase_n = 2;
                end else if (m_phase == 2 && m_dir && m_pend_rd) begin
                    data_n  = m_to_sec ? 8'(m_sec >> (8 * m_sbyte)) : m_mem[m_baddr];
                    phase_n = 0;
                end else if (m_phase == 2 && !m_dir && !m_pend_rd) begin
                    if (m_to_sec) begin
                        mask  = 32'hFF << (8 * m_sbyte);
                        sec_n = (m_sec & ~mask) | (32'(m_data) << (8 * m_sbyte));
                        if (m_sbyte == 0) presc_n = 0;
                    end else begin
                        m_mem[m_baddr] = m_data;
                    end
                    phase_n = 0;
                end
            end
        end
        if (st && !rw && !m_busy) begin
            if (!a) begin
                data_n = d;
            end else begin
                busy_n = d[7]; dir_n = d[6]; last_n = d[5]; left_n = BUSY_CEN;
                if (!d[7] && d[5]) phase_n = 0;
            end
        end
        m_data = data_n; m_busy = busy_n; m_dir = dir_n; m_last = last_n; m_left = left_n;
        m_phase = phase_n; m_presc = presc_n; m_sec = sec_n;
    endtask

    function automatic bit rc();
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic cyc(input bit st, input bit rw, input bit a, input bit [7:0] d, input bit c,
                       input string nm);
        bus.strobe = st; bus.rw = rw; bus.addr = a; bus.din = d; cen = c;
        @(posedge clk);
        model_step(st, rw, a, d, c, nm);
        #1;
    endtask

    task automatic wr(input bit a, input bit [7:0] d);
        cyc(1'b1, 1'b0, a, d, rc(), "wr");
    endtask

    task automatic rd(input bit a, input string nm);
        cyc(1'b1, 1'b1, a, 8'h00, rc(), nm);
    endtask

    task automatic wait_idle();
        int budget = 200;
        while (m_busy && budget > 0) begin
            cyc(1'b0, 1'b0, 1'b0, 8'h00, rc(), "idle");
            budget--;
        end
    endtask

    task automatic xfer(input bit [7:0] ctl);
        wr(1'b1, ctl);
        wait_idle();
    endtask

    task automatic bram_write(input bit [7:0] adr, input bit [7:0] val);
        wr(1'b0, 8'h38 | {5'b0, adr[7:5]}); xfer(8'h80);
        wr(1'b0, {1'b0, adr[4:0], 2'b00});  xfer(8'h80);
        wr(1'b0, val);                      xfer(8'h80);
    endtask

    task automatic bram_read(input bit [7:0] adr, input string nm);
        wr(1'b0, 8'hB8 | {5'b0, adr[7:5]}); xfer(8'h80);
        wr(1'b0, {1'b0, adr[4:0], 2'b00});  xfer(8'h80);
        xfer(8'hC0);
        rd(1'b0, nm);
    endtask

    task automatic sec_write(input bit [1:0] b, input bit [7:0] val);
        wr(1'b0, {4'b0000, b, 2'b01}); xfer(8'h80);
        wr(1'b0, val);                 xfer(8'h80);
    endtask

    task automatic sec_read(input bit [1:0] b, input string nm);
        wr(1'b0, {4'b1000, b, 2'b01}); xfer(8'h80);
        xfer(8'hC0);
        rd(1'b0, nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        bus.strobe = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.strobe = 1'b0; bus.rw = 1'b0; bus.addr = 1'b0; bus.din = 8'h00;
        model_reset();
        #1;
        do_reset();
        rd(1'b0, "reset_data");
        rd(1'b1, "reset_ctl");

        bram_write(8'h45, 8'h5C);
        bram_read(8'h45, "bram_45");

        // Busy window with cen every cycle; the DATA write lands mid-transfer.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, "wr");
        cyc(1'b1, 1'b0, 1'b1, 8'h80, 1'b1, "wr");
        repeat (3) cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b1, "busy_ctl");
        cyc(1'b1, 1'b0, 1'b0, 8'h55, 1'b1, "wr");
        repeat (6) cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b1, "busy_ctl");
        rd(1'b0, "data_kept_during_busy");
        xfer(8'hC0);
        rd(1'b0, "invalid_cmd_data");

        sec_write(2'd3, 8'hFF);
        sec_write(2'd2, 8'hFF);
        sec_write(2'd1, 8'hFF);
        sec_write(2'd0, 8'hFF);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "idle");
        sec_read(2'd0, "sec_byte0_wrap");
        sec_read(2'd3, "sec_byte3_wrap");

        wr(1'b0, 8'h3A); xfer(8'h80);
        wr(1'b1, 8'h20);
        rd(1'b1, "abort_ctl");
        sec_read(2'd1, "sec_after_abort");

        wr(1'b0, 8'h3A); xfer(8'h80);
        wr(1'b0, 8'h14); xfer(8'h80);
        wr(1'b0, 8'h77); wr(1'b1, 8'h80);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "idle");
        do_reset();
        rd(1'b1, "rst_ctl");
        rd(1'b0, "rst_data");
        bram_read(8'h45, "bram_after_rst");

        for (int k = 0; k < 4; k++) begin
            bit [7:0] adr, val;
            adr = 8'($urandom);
            val = 8'($urandom);
            bram_write(adr, val);
            bram_read(adr, "bram_rand");
        end

        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 2)      wr(1'b0, 8'($urandom));
            else if (op <= 4) wr(1'b1, 8'($urandom));
            else if (op <= 8) rd(1'($urandom), "rand_rd");
            else              cyc(1'b0, 1'b0, 1'b0, 8'h00, rc(), "idle");
        end

        repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "idle");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
